// File: rtl/multislice_adder_pkg.sv
// multislice_adder_pkg
//   Shared definitions for the multi-cycle slice adder:
//   - mode encodings (ADD / SUB / ADC / SBB)
//   - controller state encoding
//   - configuration check used at elaboration time by the top
package multislice_adder_pkg;

  // Operation modes. Bit 0 selects "invert B" (subtract family).
  // Bit 1 selects "carry-in comes from the carry_in port".
  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ADC = 2'b10;
  localparam logic [1:0] MODE_SBB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

  // Operand width must be a positive whole number of slices.
  function automatic bit slice_cfg_ok(input int width, input int slice);
    return (width > 0) && (slice > 0) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/multislice_adder_slice_adder.sv
// slice_adder
//   Combinational SLICE-bit adder used once per clock by the top.
//   Ports:
//     a, b   : SLICE-bit operands (b already inverted for subtraction)
//     cin    : carry into bit 0
//     sum    : SLICE-bit sum
//     cout   : carry out of the slice MSB
//     c_msb  : carry into the slice MSB (for signed overflow)
module slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  // Full SLICE+1 bit sum so the carry is never truncated away.
  logic [SLICE:0] wide_sum;

  always_comb begin
    wide_sum = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    sum      = wide_sum[SLICE-1:0];
    cout     = wide_sum[SLICE];
    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB is recovered
    // from the MSB sum bit.
    c_msb    = a[SLICE-1] ^ b[SLICE-1] ^ wide_sum[SLICE-1];
  end

endmodule

// File: rtl/multislice_adder.sv
// multislice_adder
//   Multi-cycle WIDTH-bit adder/subtractor that processes SLICE bits per
//   clock, LSB first, with a registered carry between slices.
//   Ports:
//     clk, rst_n   : clock (rising edge), async active-low reset
//     start        : request, accepted in IDLE or FIN
//     mode         : 00 ADD, 01 SUB, 10 ADC, 11 SBB (latched with start)
//     input1       : augend / minuend (latched with start)
//     input2       : addend / subtrahend (latched with start)
//     carry_in     : carry for ADC, not-borrow for SBB (latched with start)
//     busy         : operation in progress (RUN state)
//     done         : one-cycle pulse, results just updated
//     result       : WIDTH-bit result
//     carry        : carry out of bit WIDTH-1 (1 = no borrow when subtracting)
//     zero         : result == 0
//     overflow     : two's-complement overflow
module multislice_adder
  import multislice_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  generate
    if (!slice_cfg_ok(WIDTH, SLICE)) begin : g_bad_cfg
      $error("multislice_adder: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  state_e state_reg, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;      // stored pre-inverted for SUB/SBB
  logic [WIDTH-1:0] part_reg;   // partial result, never visible outside
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;

  logic [WIDTH-1:0] result_reg;
  logic             carry_out_reg;
  logic             zero_reg;
  logic             ovf_reg;

  logic             load;
  logic             step;
  logic             last;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_c_msb;
  logic [WIDTH-1:0] part_next;

  assign last = (idx_reg == IDX_LAST);

  // Controller: next state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_next = FIN;
      end
      FIN: begin
        done = 1'b1;
        // A new request here is accepted without an idle gap.
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Slice selection by index; the single adder is time-shared.
  always_comb begin
    a_slice   = a_reg[idx_reg*SLICE +: SLICE];
    b_slice   = b_reg[idx_reg*SLICE +: SLICE];
    part_next = part_reg;
    part_next[idx_reg*SLICE +: SLICE] = slice_sum;
  end

  slice_adder #(.SLICE(SLICE)) u_slice_adder (
    .a     (a_slice),
    .b     (b_slice),
    .cin   (carry_reg),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_c_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      part_reg      <= '0;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      result_reg    <= '0;
      carry_out_reg <= 1'b0;
      zero_reg      <= 1'b1;
      ovf_reg       <= 1'b0;
    end else if (load) begin
      a_reg     <= input1;
      b_reg     <= mode[0] ? ~input2 : input2;
      // SUB forces carry-in 1 (true borrow); ADC/SBB take the port value.
      carry_reg <= mode[1] ? carry_in : mode[0];
      idx_reg   <= '0;
    end else if (step) begin
      part_reg  <= part_next;
      carry_reg <= slice_cout;
      if (last) begin
        idx_reg       <= '0;
        result_reg    <= part_next;
        carry_out_reg <= slice_cout;
        zero_reg      <= (part_next == '0);
        ovf_reg       <= slice_cout ^ slice_c_msb;
      end else begin
        idx_reg <= idx_reg + IDX_W'(1);
      end
    end
  end

  assign result   = result_reg;
  assign carry    = carry_out_reg;
  assign zero     = zero_reg;
  assign overflow = ovf_reg;

endmodule

// File: doc/multislice_adder.md
# multislice_adder

Parametrised multi-cycle adder/subtractor for the ALU datapath. Processes a WIDTH-bit operand pair SLICE bits per clock, starting at the LSB and rippling a registered carry between slices. Adds carry-in modes for multi-word arithmetic, and zero and signed-overflow flags. Uses a START/BUSY/DONE handshake so the sequencer can issue wide operations on narrow adder hardware.

## Interface
- WIDTH, 16, operand/result width in bits; must be a positive multiple of SLICE
- SLICE, 4, bits added per clock; NSLICE = WIDTH/SLICE compute cycles

- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  request; sampled only while BUSY=0
- MODE  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBB; latched with START
- INPUT1  in  WIDTH  minuend/augend; latched with START
- INPUT2  in  WIDTH  subtrahend/addend; latched with START
- CARRY_IN  in  1  carry for ADC, not-borrow for SBB; latched with START
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle pulse: results just updated
- OUTPUT  out  WIDTH  result
- CARRY  out  1  carry out of bit WIDTH-1; for SUB/SBB, 1 = no borrow
- ZERO  out  1  OUTPUT == 0
- OVERFLOW  out  1  two's-complement overflow

## Operation
- Effective operation: INPUT1 + B' + cin.
  - ADD: B'=INPUT2, cin=0.
  - SUB: B'=~INPUT2, cin=1.
  - ADC: B'=INPUT2, cin=CARRY_IN.
  - SBB: B'=~INPUT2, cin=CARRY_IN.
- SUB always uses a true borrow. Example: 0x0000−0x0000 → CARRY=1.
- The result is exact modulo 2^WIDTH. All internal sums are SLICE+1 bits wide; there is no truncation before the carry is extracted.
- FSM states: IDLE, RUN, FIN.
  - IDLE: START=1 → latch operands/mode/cin, slice index=0, carry reg=cin, go to RUN.
  - RUN: each edge adds slice[idx] of the latched operands plus the carry reg, writes the partial-result register, updates the carry reg, and increments idx. The edge processing idx=NSLICE−1 goes to FIN.
  - FIN: one cycle. DONE=1 and BUSY=0. If START=1, it is accepted exactly as in IDLE (next state RUN); otherwise go to IDLE.
- OUTPUT, CARRY, ZERO and OVERFLOW are registered together on the edge entering FIN. They hold their values until the next completion; partial results are never visible.
- OVERFLOW = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1), taken from the last slice.
- START while BUSY=1 is ignored, with no queuing. Input changes while BUSY=1 have no effect.
- SLICE=WIDTH is legal: NSLICE=1.

## Timing
- Reset values (asynchronous, while RST_N=0): state IDLE, BUSY=0, DONE=0, OUTPUT=0, CARRY=0, ZERO=1, OVERFLOW=0. The idx, carry and partial registers are cleared.
- START sampled at edge E0:
  - BUSY=1 from E0 to E_NSLICE.
  - DONE=1 and results valid in the cycle after edge E_NSLICE.
  - Latency from the START edge to DONE high is NSLICE edges; throughput is one operation per NSLICE+1 cycles.
- BUSY=0 during IDLE and FIN.
- Reset asserted mid-RUN aborts the operation and restores the reset values. No DONE is produced.

## Structure
- Shared package/include holds:
  - MODE encodings: MODE_ADD, MODE_SUB, MODE_ADC, MODE_SBB.
  - FSM state encodings.
  - WIDTH % SLICE == 0 elaboration check.
- Sub-module slice_adder (combinational): inputs A[SLICE], B[SLICE], CIN; outputs SUM[SLICE], COUT, C_MSB (carry into MSB). It is instantiated once; the top block muxes slices by idx.

## Test plan
- Use WIDTH=16, SLICE=4 unless stated.
- ADD 0x1234+0x0FFF → OUTPUT 0x2233, C=0, Z=0, V=0. DONE high exactly 4 edges after the START edge; BUSY high for 4 cycles.
- SUB 0x0000−0x0001 → 0xFFFF, C=0, V=0. SUB 0x8000−0x0001 → 0x7FFF, C=1, V=1. SUB 0x0005−0x0000 → 0x0005, C=1.
- ADC 0xFFFF+0x0000 with CARRY_IN=1 → 0x0000, C=1, Z=1, V=0. ADD 0x7FFF+0x0001 → 0x8000, V=1.
- 32-bit chain: ADD low words 0xFFFF+0x0001 (C=1), then ADC high words 0x0001+0x0000 with CARRY_IN=C → 0x0002. Issue the second START during FIN; it must be accepted with no idle cycle.
- Edge cases:
  - START pulses while BUSY and operand changes mid-RUN leave the result unchanged.
  - RST_N low at the 2nd RUN cycle → all outputs at reset values, no DONE.
  - Re-run with WIDTH=8, SLICE=8: ADD 0xF0+0x20 → 0x10, C=1, DONE one edge after START.
